// File: rtl/ring_counter_n_if.sv
// Control and status bundle for the N-bit ring/Johnson sequencer.
// master drives the controls, slave is the sequencer itself.
interface ring_counter_n_if #(
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(2*WIDTH);

  logic             enable;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [IW-1:0]    index;
  logic             valid;
  logic             wrap;
  logic             err;

  modport master (
    output enable, dir, mode, load, load_val,
    input  q, index, valid, wrap, err
  );

  modport slave (
    input  enable, dir, mode, load, load_val,
    output q, index, valid, wrap, err
  );
endinterface

// File: rtl/ring_counter_n.sv
// N-bit one-hot ring / Johnson sequencer with up/down stepping,
// parallel load, wrap pulse and illegal-code self-recovery.
module ring_counter_n #(
  parameter int WIDTH      = 4,
  parameter bit RESET_MODE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  ring_counter_n_if.slave    bus
);
  localparam int IW   = $clog2(2*WIDTH);
  localparam int LEN0 = WIDTH;
  localparam int LEN1 = 2*WIDTH;

  logic [WIDTH-1:0] q_q, q_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             valid_c;
  int               idx_c;
  int               pop;
  int               trans;
  int               ring_idx;
  logic [WIDTH-1:0] step_c;

  function automatic logic [WIDTH-1:0] rst_pat(input logic m);
    return m ? '0 : WIDTH'(1);
  endfunction

  // Johnson codes are exactly those with at most one bit transition
  always_comb begin
    pop      = 0;
    trans    = 0;
    ring_idx = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_q[i]) begin
        pop      = pop + 1;
        ring_idx = i;
      end
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      if (q_q[i] != q_q[i+1]) trans = trans + 1;
    end
    if (!mode_q) begin
      valid_c = (pop == 1);
      idx_c   = ring_idx;
    end else begin
      valid_c = (trans <= 1);
      if (q_q == '0)  idx_c = 0;
      else if (q_q[0]) idx_c = pop;
      else             idx_c = LEN1 - pop;
    end
    if (!valid_c) idx_c = 0;
  end

  always_comb begin
    if (bus.dir)
      step_c = {q_q[0] ^ mode_q, q_q[WIDTH-1:1]};
    else
      step_c = {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ mode_q};
  end

  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.load) begin
      q_d    = bus.load_val;
      mode_d = bus.mode;
    end else if (bus.mode != mode_q) begin
      mode_d = bus.mode;
      q_d    = rst_pat(bus.mode);
    end else if (bus.enable && !valid_c) begin
      q_d   = rst_pat(mode_q);
      err_d = 1'b1;
    end else if (bus.enable) begin
      q_d = step_c;
      if (bus.dir)
        wrap_d = (idx_c == 0);
      else
        wrap_d = (idx_c == (mode_q ? LEN1 - 1 : LEN0 - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= rst_pat(RESET_MODE);
      mode_q <= RESET_MODE;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.index = IW'(idx_c);
  assign bus.valid = valid_c;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_ring_counter_n.sv
// Bench for ring_counter_n: directed scenarios plus random stimulus,
// two builds (RESET_MODE 0 and 1) checked against a sequence-table model.
module tb_ring_counter_n;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  ring_counter_n_if #(.WIDTH(W)) bus0 ();
  ring_counter_n_if #(.WIDTH(W)) bus1 ();

  ring_counter_n #(.WIDTH(W), .RESET_MODE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  ring_counter_n #(.WIDTH(W), .RESET_MODE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  // model state per build
  int mq[2];
  bit mm[2];
  bit mw[2];
  bit me[2];

  function automatic int seqlen(bit m);
    return m ? 2*W : W;
  endfunction

  // k-th code of the sequence for a mode
  function automatic int code(bit m, int k);
    if (!m) return 1 << k;
    if (k <= W) return (1 << k) - 1;
    return ((1 << W) - 1) & ~((1 << (k - W)) - 1);
  endfunction

  function automatic int lookup(bit m, int v);
    for (int k = 0; k < seqlen(m); k++)
      if (code(m, k) == v) return k;
    return -1;
  endfunction

  task automatic mreset(int i);
    mm[i] = (i == 1);
    mq[i] = code(mm[i], 0);
    mw[i] = 0;
    me[i] = 0;
  endtask

  task automatic medge(int i);
    int k;
    int n;
    int len;
    mw[i] = 0;
    me[i] = 0;
    if (bus0.load) begin
      mq[i] = int'(bus0.load_val);
      mm[i] = bus0.mode;
    end else if (bus0.mode != mm[i]) begin
      mm[i] = bus0.mode;
      mq[i] = code(mm[i], 0);
    end else if (bus0.enable) begin
      k = lookup(mm[i], mq[i]);
      len = seqlen(mm[i]);
      if (k < 0) begin
        mq[i] = code(mm[i], 0);
        me[i] = 1;
      end else begin
        n = bus0.dir ? (k + len - 1) % len : (k + 1) % len;
        mw[i] = bus0.dir ? (k == 0) : (k == len - 1);
        mq[i] = code(mm[i], n);
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] ex);
    nvec++;
    assert (obs === ex) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  task automatic cmp(int i);
    int k;
    k = lookup(mm[i], mq[i]);
    if (i == 0) begin
      chk("d0.q",     32'(bus0.q),     32'(mq[0]));
      chk("d0.index", 32'(bus0.index), 32'(k < 0 ? 0 : k));
      chk("d0.valid", 32'(bus0.valid), 32'(k >= 0));
      chk("d0.wrap",  32'(bus0.wrap),  32'(mw[0]));
      chk("d0.err",   32'(bus0.err),   32'(me[0]));
    end else begin
      chk("d1.q",     32'(bus1.q),     32'(mq[1]));
      chk("d1.index", 32'(bus1.index), 32'(k < 0 ? 0 : k));
      chk("d1.valid", 32'(bus1.valid), 32'(k >= 0));
      chk("d1.wrap",  32'(bus1.wrap),  32'(mw[1]));
      chk("d1.err",   32'(bus1.err),   32'(me[1]));
    end
  endtask

  task automatic drive(bit en, bit d, bit m, bit l, logic [W-1:0] lv);
    bus0.enable = en; bus1.enable = en;
    bus0.dir = d;     bus1.dir = d;
    bus0.mode = m;    bus1.mode = m;
    bus0.load = l;    bus1.load = l;
    bus0.load_val = lv; bus1.load_val = lv;
  endtask

  task automatic step();
    @(posedge clk);
    medge(0);
    medge(1);
    @(negedge clk);
    cmp(0);
    cmp(1);
  endtask

  // asynchronous reset applied between edges
  task automatic do_reset();
    reset = 1'b1;
    #1;
    mreset(0);
    mreset(1);
    cmp(0);
    cmp(1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] t1q [4];
    logic [W-1:0] t3q [8];
    t1q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t3q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
            4'b1110, 4'b1100, 4'b1000, 4'b0000};
    drive(0, 0, 0, 0, '0);
    #2;
    do_reset();
    chk("rst.d0q", 32'(bus0.q), 32'h1);
    chk("rst.d1q", 32'(bus1.q), 32'h0);

    // T1 ring up
    drive(1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("T1.q",    32'(bus0.q),     32'(t1q[i]));
      chk("T1.idx",  32'(bus0.index), 32'((i + 1) % 4));
      chk("T1.wrap", 32'(bus0.wrap),  32'(i == 3));
    end

    // T2 ring down, then hold
    drive(1, 1, 0, 0, '0);
    step();
    chk("T2.q",    32'(bus0.q),     32'h8);
    chk("T2.idx",  32'(bus0.index), 32'd3);
    chk("T2.wrap", 32'(bus0.wrap),  32'd1);
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("T2.hold", 32'(bus0.q),    32'h8);
      chk("T2.nw",   32'(bus0.wrap), 32'd0);
    end

    // T3 Johnson up
    drive(1, 0, 1, 0, '0);
    step();
    chk("T3.init", 32'(bus0.q), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("T3.q",    32'(bus0.q),     32'(t3q[i]));
      chk("T3.idx",  32'(bus0.index), 32'((i + 1) % 8));
      chk("T3.wrap", 32'(bus0.wrap),  32'(i == 7));
    end

    // T4 illegal load, hold, recover
    drive(0, 0, 0, 1, 4'b0110);
    step();
    chk("T4.q",     32'(bus0.q),     32'h6);
    chk("T4.valid", 32'(bus0.valid), 32'd0);
    chk("T4.idx",   32'(bus0.index), 32'd0);
    drive(0, 0, 0, 0, '0);
    step();
    step();
    chk("T4.hold", 32'(bus0.q), 32'h6);
    drive(1, 0, 0, 0, '0);
    step();
    chk("T4.rec", 32'(bus0.q),   32'h1);
    chk("T4.err", 32'(bus0.err), 32'd1);
    drive(0, 0, 0, 0, '0);
    step();
    chk("T4.err0", 32'(bus0.err), 32'd0);

    // T5 mode change overrides a step
    drive(1, 0, 0, 0, '0);
    step();
    step();
    chk("T5.pre", 32'(bus0.q), 32'h4);
    drive(1, 0, 1, 0, '0);
    step();
    chk("T5.q",     32'(bus0.q),     32'h0);
    chk("T5.wrap",  32'(bus0.wrap),  32'd0);
    chk("T5.valid", 32'(bus0.valid), 32'd1);

    // T6 Johnson at 0111, async reset
    for (int i = 0; i < 3; i++) step();
    chk("T6.pre", 32'(bus0.q), 32'h7);
    do_reset();
    chk("T6.d0q",   32'(bus0.q),     32'h1);
    chk("T6.d0idx", 32'(bus0.index), 32'd0);
    chk("T6.d1q",   32'(bus1.q),     32'h0);

    // random phase
    begin
      bit m;
      m = 0;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 19) == 0) m = ~m;
        drive($urandom_range(0, 3) != 0, 1'($urandom), m,
              $urandom_range(0, 15) == 0, W'($urandom));
        if ($urandom_range(0, 49) == 0) do_reset();
        else step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
